// File: rtl/clk_div_bank_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_bank_pkg : register map and channel configuration type
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package clk_div_bank_pkg;

   localparam logic [11:0] CFG_OFFS    = 12'h000;
   localparam logic [11:0] STATUS_OFFS = 12'h040;

   localparam int EN_BIT    = 31;
   localparam int PEND_BIT  = 30;
   localparam int MAX_DIV_W = 24;

   typedef struct packed {
      logic                 en;
      logic [MAX_DIV_W-1:0] div;
   } ch_cfg_t;

endpackage

`default_nettype wire

// File: rtl/clk_div_ch.sv
// ----------------------------------------------------------------------------
// clk_div_ch : one divider channel with shadow/active config and bypass mux
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clk_div_ch
   import clk_div_bank_pkg::*;
#(
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned DEFAULT_DIV = 2,
   parameter logic        DEFAULT_EN  = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             test_mode_i,
   input  logic             wr_en,
   input  ch_cfg_t          wr_cfg,
   output logic [DIV_W-1:0] div_s,
   output logic             en_s,
   output logic             pend,
   output logic             running,
   output logic             clk_o,
   output logic             stb_o
);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;
   logic             en_q;
   logic             clk_r;
   logic             wrap;
   logic             xfer;
   logic             bypass_req;
   logic             bypass_sel;
   logic             unused_cfg;

   assign unused_cfg = ^wr_cfg;

   // Divisors below 2 never count, so every cycle is a wrap cycle.
   assign wrap = (div_q < DIV_W'(2)) || (cnt == div_q - DIV_W'(1));
   assign xfer = ~en_q | wrap;

   assign pend    = (div_s != div_q) || (en_s != en_q);
   assign running = en_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q <= DIV_W'(DEFAULT_DIV);
         div_s <= DIV_W'(DEFAULT_DIV);
         en_q  <= DEFAULT_EN;
         en_s  <= DEFAULT_EN;
         cnt   <= '0;
         clk_r <= 1'b0;
         stb_o <= 1'b0;
      end else begin
         if (wr_en) begin
            div_s <= wr_cfg.div[DIV_W-1:0];
            en_s  <= wr_cfg.en;
         end
         if (xfer) begin
            div_q <= div_s;
            en_q  <= en_s;
            cnt   <= '0;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
         clk_r <= en_q && (cnt < (div_q >> 1));
         stb_o <= en_q && (cnt == '0);
      end
   end

   // Select changes only while clk_i is low, so the clk_i path never
   // contributes a truncated high phase.
   assign bypass_req = test_mode_i | (en_q & (div_q < DIV_W'(2)));

   always_ff @(negedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bypass_sel <= 1'b0;
      end else begin
         bypass_sel <= bypass_req;
      end
   end

   assign clk_o = bypass_sel ? clk_i : clk_r;

endmodule

`default_nettype wire

// File: rtl/clk_div_bank.sv
// ----------------------------------------------------------------------------
// clk_div_bank : APB-programmable bank of NUM_CH integer clock dividers
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clk_div_bank
   import clk_div_bank_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned DEFAULT_DIV = 2,
   parameter logic        DEFAULT_EN  = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              test_mode_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [11:0]       paddr_i,
   input  logic [31:0]       pwdata_i,
   output logic [31:0]       prdata_o,
   output logic              pready_o,
   output logic              pslverr_o,
   output logic [NUM_CH-1:0] clk_o,
   output logic [NUM_CH-1:0] stb_o
);

   logic              access;
   logic [9:0]        cfg_idx;
   logic              cfg_hit;
   logic              status_hit;
   logic              err;
   ch_cfg_t           wr_cfg;
   logic [31:0]       cfg_word [NUM_CH];
   logic [NUM_CH-1:0] running;
   logic              unused_bits;

   assign unused_bits = ^{paddr_i[1:0], pwdata_i[PEND_BIT:MAX_DIV_W]};

   assign access     = psel_i & penable_i;
   assign cfg_idx    = paddr_i[11:2] - CFG_OFFS[11:2];
   assign cfg_hit    = cfg_idx < 10'(NUM_CH);
   assign status_hit = paddr_i[11:2] == STATUS_OFFS[11:2];
   assign err        = access & ~(cfg_hit | (status_hit & ~pwrite_i));

   assign pready_o  = 1'b1;
   assign pslverr_o = err;

   assign wr_cfg.en  = pwdata_i[EN_BIT];
   assign wr_cfg.div = pwdata_i[MAX_DIV_W-1:0];

   generate
      for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
         logic [DIV_W-1:0] div_s;
         logic             en_s;
         logic             pend;
         logic             wr_en;

         assign wr_en = access & pwrite_i & (cfg_idx == 10'(n));

         clk_div_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .DEFAULT_EN  (DEFAULT_EN)
         ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .test_mode_i (test_mode_i),
            .wr_en       (wr_en),
            .wr_cfg      (wr_cfg),
            .div_s       (div_s),
            .en_s        (en_s),
            .pend        (pend),
            .running     (running[n]),
            .clk_o       (clk_o[n]),
            .stb_o       (stb_o[n])
         );

         assign cfg_word[n] = {en_s, pend, {(30-DIV_W){1'b0}}, div_s};
      end
   endgenerate

   always_comb begin
      prdata_o = '0;
      if (access && !err) begin
         if (status_hit) begin
            prdata_o = 32'(running);
         end
         for (int n = 0; n < NUM_CH; n++) begin
            if (cfg_idx == 10'(n)) begin
               prdata_o = cfg_word[n];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// ----------------------------------------------------------------------------
// tb_clk_div_bank : directed scoreboard bench for clk_div_bank
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_bank;

   localparam int NUM_CH = 4;

   logic              clk       = 1'b0;
   logic              rst       = 1'b0;
   logic              test_mode = 1'b0;
   logic              psel      = 1'b0;
   logic              penable   = 1'b0;
   logic              pwrite    = 1'b0;
   logic [11:0]       paddr     = '0;
   logic [31:0]       pwdata    = '0;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;
   logic [NUM_CH-1:0] clk_o;
   logic [NUM_CH-1:0] stb_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   clk_div_bank #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (16),
      .DEFAULT_DIV (2),
      .DEFAULT_EN  (1'b1)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .test_mode_i (test_mode),
      .psel_i      (psel),
      .penable_i   (penable),
      .pwrite_i    (pwrite),
      .paddr_i     (paddr),
      .pwdata_i    (pwdata),
      .prdata_o    (prdata),
      .pready_o    (pready),
      .pslverr_o   (pslverr),
      .clk_o       (clk_o),
      .stb_o       (stb_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge; returns just after a falling edge.
   task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                            input logic exp_err, input string tag);
      exp_t e;
      exp_q.push_back('{tag, 32'h0, exp_err});
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      #1;
      e = exp_q.pop_front();
      check({e.tag, "_err"}, 32'(pslverr), 32'(e.err));
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, input logic [31:0] d,
                           input logic exp_err, input string tag);
      exp_t e;
      exp_q.push_back('{tag, d, exp_err});
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(negedge clk);
      penable = 1'b1;
      #1;
      e = exp_q.pop_front();
      check(e.tag, prdata, e.data);
      check({e.tag, "_err"}, 32'(pslverr), 32'(e.err));
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   // High/low run lengths of one full divided period, sampled at falling edges.
   task automatic measure(input int ch, output int hi, output int lo);
      int guard;
      guard = 0; hi = 0; lo = 0;
      while (clk_o[ch] !== 1'b0 && guard < 64) begin @(negedge clk); guard++; end
      while (clk_o[ch] !== 1'b1 && guard < 64) begin @(negedge clk); guard++; end
      while (clk_o[ch] === 1'b1 && guard < 64) begin hi++; @(negedge clk); guard++; end
      while (clk_o[ch] === 1'b0 && guard < 64) begin lo++; @(negedge clk); guard++; end
      check($sformatf("measure%0d_bound", ch), 32'(guard < 64), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, lo, cnt, guard;
      logic hi_and, lo_or, stb_and, clk_or, stb_or;

      // Reset state
      #2 rst = 1'b1;
      #6;
      check("rst_clk_o", 32'(clk_o), 32'h0);
      check("rst_stb_o", 32'(stb_o), 32'h0);
      check("rst_prdata", prdata, 32'h0);
      check("rst_pslverr", 32'(pslverr), 32'h0);
      check("pready", 32'(pready), 32'h1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("first_stb", 32'(stb_o), 32'hF);
      check("first_clk_high", 32'(clk_o), 32'hF);

      for (int n = 0; n < NUM_CH; n++) begin
         apb_read(12'(4 * n), 32'h8000_0002, 1'b0, $sformatf("cfg%0d_rst", n));
      end
      apb_read(12'h040, 32'h0000_000F, 1'b0, "status_rst");

      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         cnt += int'(stb_o[0]);
      end
      check("stb_rate_div2", 32'(cnt), 32'd10);
      measure(3, hi, lo);
      check("div2_high", 32'(hi), 32'd1);
      check("div2_low", 32'(lo), 32'd1);

      // Ratio change on channel 1, written in its wrap cycle
      guard = 0;
      while (clk_o[1] !== 1'b0 && guard < 4) begin @(negedge clk); guard++; end
      apb_write(12'h004, 32'h8000_0005, 1'b0, "wr_cfg1");
      apb_read(12'h004, 32'hC000_0005, 1'b0, "cfg1_pend");
      measure(1, hi, lo);
      check("div5_high", 32'(hi), 32'd2);
      check("div5_low", 32'(lo), 32'd3);
      apb_read(12'h004, 32'h8000_0005, 1'b0, "cfg1_applied");

      // Bypass via divisor 1 on channel 2
      apb_write(12'h008, 32'h8000_0001, 1'b0, "wr_cfg2");
      repeat (4) @(negedge clk);
      hi_and = 1'b1; lo_or = 1'b0; stb_and = 1'b1;
      repeat (4) begin
         @(posedge clk); #2;
         hi_and &= clk_o[2];
         @(negedge clk); #2;
         lo_or |= clk_o[2];
         stb_and &= stb_o[2];
      end
      @(negedge clk);
      check("bypass_high", 32'(hi_and), 32'd1);
      check("bypass_low", 32'(lo_or), 32'd0);
      check("bypass_stb", 32'(stb_and), 32'd1);
      apb_read(12'h040, 32'h0000_000F, 1'b0, "status_bypass");

      // Disable channel 0, then re-enable
      apb_write(12'h000, 32'h0000_0004, 1'b0, "wr_cfg0_off");
      repeat (4) @(negedge clk);
      clk_or = 1'b0; stb_or = 1'b0;
      repeat (8) begin
         @(negedge clk);
         clk_or |= clk_o[0];
         stb_or |= stb_o[0];
      end
      check("off_clk", 32'(clk_or), 32'd0);
      check("off_stb", 32'(stb_or), 32'd0);
      apb_read(12'h040, 32'h0000_000E, 1'b0, "status_off");
      apb_read(12'h000, 32'h0000_0004, 1'b0, "cfg0_off");
      apb_write(12'h000, 32'h8000_0004, 1'b0, "wr_cfg0_on");
      @(negedge clk);
      check("restart_low", 32'(clk_o[0]), 32'd0);
      check("restart_no_stb", 32'(stb_o[0]), 32'd0);
      @(negedge clk);
      check("restart_high", 32'(clk_o[0]), 32'd1);
      check("restart_stb", 32'(stb_o[0]), 32'd1);
      measure(0, hi, lo);
      check("div4_high", 32'(hi), 32'd2);
      check("div4_low", 32'(lo), 32'd2);

      // Error accesses leave state untouched
      apb_write(12'h040, 32'hFFFF_FFFF, 1'b1, "wr_status");
      apb_write(12'h080, 32'h0000_0003, 1'b1, "wr_0x80");
      apb_read(12'h080, 32'h0000_0000, 1'b1, "rd_0x80");
      apb_read(12'h000, 32'h8000_0004, 1'b0, "cfg0_after_err");
      apb_read(12'h004, 32'h8000_0005, 1'b0, "cfg1_after_err");
      apb_read(12'h008, 32'h8000_0001, 1'b0, "cfg2_after_err");
      apb_read(12'h00C, 32'h8000_0002, 1'b0, "cfg3_after_err");
      apb_read(12'h040, 32'h0000_000F, 1'b0, "status_after_err");

      // Test mode, then asynchronous reset while clk is high
      test_mode = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      check("tm_high", 32'(clk_o), 32'hF);
      @(negedge clk); #2;
      check("tm_low", 32'(clk_o), 32'h0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("async_rst_clk", 32'(clk_o), 32'h0);
      check("async_rst_stb", 32'(stb_o), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      test_mode = 1'b0;
      @(negedge clk);
      apb_read(12'h004, 32'h8000_0002, 1'b0, "cfg1_post_rst");
      apb_read(12'h000, 32'h8000_0002, 1'b0, "cfg0_post_rst");
      apb_read(12'h040, 32'h0000_000F, 1'b0, "status_post_rst");

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
